preg_free_list: RTL and testbench

- Manages the pool of 64 physical registers for the 2-wide rename stage.
- Hands out up to two free physical registers per cycle to rename slots 1 and 2.
- Takes back up to two old physical registers per cycle from retire (retire_flag_1/fp_ind_1, retire_flag_2/fp_ind_2).
- Circular FIFO plus a free bitmap that detects double-free; stalls rename when the pool cannot satisfy a request.

---
 rtl/preg_free_list_pkg.sv | 20 ++
 rtl/preg_free_list.sv | 116 +++++++++++
 tb/tb_preg_free_list.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/preg_free_list_pkg.sv
// Shared physical-register constants and types for rename, dispatch and complete.
package preg_free_list_pkg;

  localparam int NUM_PREGS = 64;               // physical register count, power of two
  localparam int NUM_AREGS = 32;               // p0..p31 are RAT-mapped at reset
  localparam int PREG_W    = $clog2(NUM_PREGS);
  localparam int NUM_LANES = 2;                // rename / retire width

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [PREG_W:0]   cnt_t;

  // Number of pregs free straight out of reset.
  localparam cnt_t RESET_FREE = cnt_t'(NUM_PREGS - NUM_AREGS);

  // Reset contents of FIFO slot i: the unmapped pregs in ascending order.
  function automatic preg_t reset_slot(input int i);
    return (i < NUM_PREGS - NUM_AREGS) ? preg_t'(NUM_AREGS + i) : '0;
  endfunction

endpackage

// File: rtl/preg_free_list.sv
// Free list for the 2-wide rename stage: a circular FIFO of free pregs plus a
// free bitmap that guards against double-free. Allocation is all-or-nothing
// and reads the FIFO combinationally; releases enqueue at the tail.
module preg_free_list
  import preg_free_list_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req_1,
  input  logic              alloc_req_2,
  output logic              alloc_grant,
  output logic [PREG_W-1:0] alloc_preg_1,
  output logic [PREG_W-1:0] alloc_preg_2,
  input  logic              rel_valid_1,
  input  logic [PREG_W-1:0] rel_preg_1,
  input  logic              rel_valid_2,
  input  logic [PREG_W-1:0] rel_preg_2,
  output logic [PREG_W:0]   free_count,
  output logic              empty,
  output logic              dfree_err
);

  // Storage: slot order is allocation order; bitmap[p]=1 means p sits in the FIFO.
  preg_t [NUM_PREGS-1:0] fifo;
  logic  [NUM_PREGS-1:0] bitmap;
  preg_t                 head;
  preg_t                 tail;

  // Per-lane views of the retire ports.
  logic  [NUM_LANES-1:0] rel_valid;
  preg_t [NUM_LANES-1:0] rel_preg;
  logic  [NUM_LANES-1:0] rel_acc;
  logic  [NUM_LANES-1:0] take;

  preg_t      head_p1;
  preg_t      wr_idx_2;
  logic [1:0] need;
  logic [1:0] need_g;
  logic [1:0] acc_n;
  logic       rel_rej;

  assign rel_valid = {rel_valid_2, rel_valid_1};
  assign rel_preg  = {rel_preg_2,  rel_preg_1};

  // Request size and combinational grant against the registered count only.
  always_comb begin
    need        = {1'b0, alloc_req_1} + {1'b0, alloc_req_2};
    alloc_grant = !rst && (cnt_t'(need) <= free_count);
    take        = {alloc_grant && alloc_req_2, alloc_grant && alloc_req_1};
    need_g      = alloc_grant ? need : 2'd0;
  end

  // Read ports: slot 1 takes the head; slot 2 takes head+1 only if slot 1 also asked.
  always_comb begin
    head_p1      = head + preg_t'(1);
    alloc_preg_1 = fifo[head];
    alloc_preg_2 = alloc_req_1 ? fifo[head_p1] : fifo[head];
  end

  // Release acceptance. The bitmap is the pre-allocation view, so a preg being
  // handed out this cycle still reads as free and its release is rejected.
  // Lane 2 loses to lane 1 when both name the same preg.
  always_comb begin
    rel_acc[0] = rel_valid[0] && (rel_preg[0] != '0) && !bitmap[rel_preg[0]];
    rel_acc[1] = rel_valid[1] && (rel_preg[1] != '0) && !bitmap[rel_preg[1]] &&
                 !(rel_acc[0] && (rel_preg[1] == rel_preg[0]));
    rel_rej    = (rel_valid[0] && !rel_acc[0]) || (rel_valid[1] && !rel_acc[1]);
    acc_n      = {1'b0, rel_acc[0]} + {1'b0, rel_acc[1]};
    wr_idx_2   = rel_acc[0] ? tail + preg_t'(1) : tail;
  end

  // FIFO contents and bitmap. Allocated bits were 1 and released bits were 0,
  // so the clears and sets below never target the same bit in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        fifo[i]   <= reset_slot(i);
        bitmap[i] <= (i >= NUM_AREGS);
      end
    end else begin
      if (take[0]) bitmap[alloc_preg_1] <= 1'b0;
      if (take[1]) bitmap[alloc_preg_2] <= 1'b0;
      if (rel_acc[0]) begin
        fifo[tail]           <= rel_preg[0];
        bitmap[rel_preg[0]]  <= 1'b1;
      end
      if (rel_acc[1]) begin
        fifo[wr_idx_2]       <= rel_preg[1];
        bitmap[rel_preg[1]]  <= 1'b1;
      end
    end
  end

  // Pointers and occupancy; the bitmap caps occupancy below NUM_PREGS, so the
  // tail can never lap the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      tail       <= preg_t'(NUM_PREGS - NUM_AREGS);
      free_count <= RESET_FREE;
    end else begin
      head       <= head + preg_t'(need_g);
      tail       <= tail + preg_t'(acc_n);
      free_count <= free_count - cnt_t'(need_g) + cnt_t'(acc_n);
    end
  end

  // Sticky double-free / illegal-release flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          dfree_err <= 1'b0;
    else if (rel_rej) dfree_err <= 1'b1;
  end

  assign empty = (free_count == '0);

endmodule

// File: tb/tb_preg_free_list.sv
// Randomised + directed bench for preg_free_list. A queue-based model of the
// free pool predicts each cycle's outputs; a monitor compares them.
module tb_preg_free_list;
  import preg_free_list_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alloc_req_1 = 0, alloc_req_2 = 0;
  logic        alloc_grant;
  logic [5:0]  alloc_preg_1, alloc_preg_2;
  logic        rel_valid_1 = 0, rel_valid_2 = 0;
  logic [5:0]  rel_preg_1 = 0, rel_preg_2 = 0;
  logic [6:0]  free_count;
  logic        empty;
  logic        dfree_err;

  preg_free_list dut (
    .clk(clk), .rst(rst),
    .alloc_req_1(alloc_req_1), .alloc_req_2(alloc_req_2),
    .alloc_grant(alloc_grant),
    .alloc_preg_1(alloc_preg_1), .alloc_preg_2(alloc_preg_2),
    .rel_valid_1(rel_valid_1), .rel_preg_1(rel_preg_1),
    .rel_valid_2(rel_valid_2), .rel_preg_2(rel_preg_2),
    .free_count(free_count), .empty(empty), .dfree_err(dfree_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit r1, r2, grant, err;
    int p1, p2, fc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference pool: fq is the free pregs in hand-out order, fs the free set.
  int fq[$];
  bit fs[64];
  bit merr;

  task automatic model_reset();
    fq.delete();
    for (int p = 0; p < 64; p++) fs[p] = (p >= 32);
    for (int p = 32; p < 64; p++) fq.push_back(p);
    merr = 0;
  endtask

  // One clock of stimulus: drive inputs, predict outputs, advance the model.
  task automatic cycle(input bit r1, input bit r2, input bit v1, input int q1,
                       input bit v2, input int q2, input bit rs);
    exp_t e;
    bit a1, a2;
    int need;
    @(negedge clk);
    rst = rs;
    alloc_req_1 = r1; alloc_req_2 = r2;
    rel_valid_1 = v1; rel_preg_1 = 6'(q1);
    rel_valid_2 = v2; rel_preg_2 = 6'(q2);
    e.r1 = r1; e.r2 = r2; e.p1 = -1; e.p2 = -1;
    if (rs) begin
      model_reset();
      e.grant = 0; e.fc = 32; e.err = 0;
      sb.push_back(e);
      return;
    end
    need    = int'(r1) + int'(r2);
    e.fc    = fq.size();
    e.err   = merr;
    e.grant = (need <= fq.size());
    if (e.grant) begin
      if (r1) e.p1 = fq[0];
      if (r2) e.p2 = r1 ? fq[1] : fq[0];
    end
    sb.push_back(e);
    // releases are judged against the pool as it stood before this cycle's grant
    a1 = v1 && q1 != 0 && !fs[q1];
    a2 = v2 && q2 != 0 && !fs[q2] && !(a1 && q1 == q2);
    if ((v1 && !a1) || (v2 && !a2)) merr = 1;
    if (e.grant) repeat (need) fs[fq.pop_front()] = 0;
    if (a1) begin fq.push_back(q1); fs[q1] = 1; end
    if (a2) begin fq.push_back(q2); fs[q2] = 1; end
  endtask

  task automatic idle(input bit r1, input bit r2);
    cycle(r1, r2, 0, 0, 0, 0, 0);
  endtask

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: every cycle that carries a prediction, compare away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("alloc_grant", int'(alloc_grant), int'(e.grant));
        if (e.grant && e.r1) chk("alloc_preg_1", int'(alloc_preg_1), e.p1);
        if (e.grant && e.r2) chk("alloc_preg_2", int'(alloc_preg_2), e.p2);
        chk("free_count", int'(free_count), e.fc);
        chk("empty", int'(empty), int'(e.fc == 0));
        chk("dfree_err", int'(dfree_err), int'(e.err));
      end
    end
  end

  initial begin
    int owned[$];
    int q1, q2;
    bit v1, v2;
    model_reset();

    // reset image, idle, then a single slot-1 request
    cycle(0, 0, 0, 0, 0, 0, 1);
    idle(0, 0);
    idle(1, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);

    // drain the pool in pairs, then requests stall
    repeat (16) idle(1, 1);
    idle(1, 1);
    idle(1, 0);
    idle(0, 1);

    // releases are not bypassed into same-cycle allocation
    cycle(1, 1, 1, 5, 1, 9, 0);
    idle(1, 1);
    idle(0, 0);

    // one free preg cannot satisfy two slots; slot 1 alone then gets it
    cycle(0, 0, 1, 20, 0, 0, 0);
    idle(1, 1);
    idle(1, 0);
    idle(0, 0);

    // illegal releases: same preg on both lanes, p0, already-free p40
    cycle(0, 0, 1, 7, 1, 7, 0);
    cycle(0, 0, 1, 40, 1, 0, 0);
    cycle(0, 0, 1, 40, 0, 0, 0);
    idle(0, 0);
    idle(0, 1);
    idle(0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    idle(0, 0);

    // random legal traffic with a reset dropped in mid-burst
    for (int c = 0; c < 200; c++) begin
      if (c == 120) begin
        cycle(1, 1, 0, 0, 0, 0, 1);
        idle(1, 0);
        continue;
      end
      owned.delete();
      for (int p = 1; p < 64; p++) if (!fs[p]) owned.push_back(p);
      v1 = 0; v2 = 0; q1 = 0; q2 = 0;
      if (owned.size() > 0 && $urandom_range(0, 99) < 55) begin
        v1 = 1; q1 = owned[$urandom_range(0, owned.size() - 1)];
      end
      if (owned.size() > 1 && $urandom_range(0, 99) < 45) begin
        do q2 = owned[$urandom_range(0, owned.size() - 1)]; while (v1 && q2 == q1);
        v2 = 1;
      end
      cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 60, v1, q1, v2, q2, 0);
    end
    idle(0, 0);

    // let the monitor drain; a stuck queue is a failure, not a hang
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
